// File: rtl/tap_line_buffer_if.sv
// ---------------------------------------------------------------------------
// tap_line_buffer_if
//   Control/data bundle between a pixel source and tap_line_buffer.
//
//   Transfer semantics: i_shift is a one-cycle strobe qualifying i_wdata.
//   The buffer never stalls, so there is no ready. Every edge with
//   i_shift=1 consumes one sample. i_clear takes priority over i_shift and
//   drops that cycle's sample. Outputs are valid every cycle, and
//   o_tap_valid marks which taps hold post-flush data.
//
//   Signals:
//     i_clear      sync flush; latches i_len as the new row length
//     i_len        row length (0 or >DEPTH selects DEPTH)
//     i_shift      advance all rows by one sample
//     i_wdata      sample entering row 0
//     o_rdata      o_rdata[k] = oldest sample of row k
//     o_tap_valid  per-tap "holds real data" flags
//     o_full       all taps valid
//     o_fill       shifts since flush, saturating at TAPS*LEN
//   Modports: master = source side, slave = buffer side.
// ---------------------------------------------------------------------------
interface tap_line_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 640,
    parameter int TAPS  = 3
);
    logic                                 i_clear;
    logic [$clog2(DEPTH+1)-1:0]           i_len;
    logic                                 i_shift;
    logic [WIDTH-1:0]                     i_wdata;
    logic [TAPS-1:0][WIDTH-1:0]           o_rdata;
    logic [TAPS-1:0]                      o_tap_valid;
    logic                                 o_full;
    logic [$clog2(TAPS*DEPTH+1)-1:0]      o_fill;

    modport master (
        output i_clear, i_len, i_shift, i_wdata,
        input  o_rdata, o_tap_valid, o_full, o_fill
    );

    modport slave (
        input  i_clear, i_len, i_shift, i_wdata,
        output o_rdata, o_tap_valid, o_full, o_fill
    );
endinterface

// File: rtl/tap_line_buffer.sv
// ---------------------------------------------------------------------------
// tap_line_buffer
//   TAPS cascaded circular rows, each of runtime length LEN (1..DEPTH).
//   All rows share one pointer. On each shift, row 0 takes the new sample
//   and row k takes the sample being evicted from row k-1. Every tap
//   presents its oldest sample at the same time, which gives the same
//   column across TAPS past lines.
//
//   Ports:
//     i_clk  clock, posedge
//     i_rst  asynchronous active-high reset
//     bus    tap_line_buffer_if.slave (clear/len/shift/wdata in; rdata,
//            tap_valid, full, fill out)
// ---------------------------------------------------------------------------
module tap_line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 640,
    parameter int TAPS  = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    tap_line_buffer_if.slave   bus
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(TAPS * DEPTH + 1);

    logic [WIDTH-1:0] r_mem [TAPS][DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [LW-1:0]    r_len;
    logic [FW-1:0]    r_fill;

    logic [LW-1:0]    w_len_load;
    logic             w_ptr_last;
    logic [FW-1:0]    w_fill_max;
    logic [TAPS-1:0]  w_tap_valid;
    logic [TAPS-1:0][WIDTH-1:0] w_rdata;

    // Out-of-range lengths fall back to the full row.
    always_comb begin
        w_len_load = bus.i_len;
        if (bus.i_len == '0 || bus.i_len > LW'(DEPTH))
            w_len_load = LW'(DEPTH);
    end

    assign w_ptr_last = (LW'(r_ptr) == (r_len - LW'(1)));
    assign w_fill_max = FW'(TAPS) * FW'(r_len);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < TAPS; k++)
                for (int d = 0; d < DEPTH; d++)
                    r_mem[k][d] <= '0;
            r_ptr  <= '0;
            r_len  <= LW'(DEPTH);
            r_fill <= '0;
        end else if (bus.i_clear) begin
            for (int k = 0; k < TAPS; k++)
                for (int d = 0; d < DEPTH; d++)
                    r_mem[k][d] <= '0;
            r_ptr  <= '0;
            r_len  <= w_len_load;
            r_fill <= '0;
        end else if (bus.i_shift) begin
            // Right-hand sides are pre-edge values, so row k receives
            // exactly the sample row k-1 is evicting at this pointer.
            r_mem[0][r_ptr] <= bus.i_wdata;
            for (int k = 1; k < TAPS; k++)
                r_mem[k][r_ptr] <= r_mem[k-1][r_ptr];
            r_ptr <= w_ptr_last ? '0 : r_ptr + 1'b1;
            if (r_fill < w_fill_max)
                r_fill <= r_fill + 1'b1;
        end
    end

    always_comb begin
        w_rdata     = '0;
        w_tap_valid = '0;
        for (int k = 0; k < TAPS; k++) begin
            w_rdata[k]     = r_mem[k][r_ptr];
            w_tap_valid[k] = (r_fill >= FW'(k + 1) * FW'(r_len));
        end
    end

    assign bus.o_rdata     = w_rdata;
    assign bus.o_tap_valid = w_tap_valid;
    assign bus.o_full      = w_tap_valid[TAPS-1];
    assign bus.o_fill      = r_fill;
endmodule
